row_packer: RTL and testbench
=============================

ROW_PACKER -- requirements
Module: row_packer

Interface
REQ-001 Parameter COL, default 256, pixels per image row.
REQ-002 Parameter ROW, default 256, rows per frame.
REQ-003 Parameter WIDTH, default 8, bits per colour channel; a pixel is 3*WIDTH bits, R in the MSBs and B in the LSBs.
REQ-004 CLK  input  1  single clock for all state; rising-edge.
REQ-005 RST  input  1  reset, asynchronous assert, active-low; 0 resets the block.
REQ-006 pix_in  input  3*WIDTH  serial RGB pixel, raster order.
REQ-007 pix_valid  input  1  pix_in valid this cycle.
REQ-008 pix_ready  output  1  block accepts pix_in this cycle.
REQ-009 row_out  output  COL*WIDTH*3  assembled row; pixel 0 in bits [COL*3*WIDTH-1 -: 3*WIDTH], pixel COL-1 in the LSBs.
REQ-010 row_valid  output  1  row_out holds a complete row.
REQ-011 row_ready  input  1  downstream filter consumes row_out this cycle.
REQ-012 SET  output  1  high with row_valid when row_out is row 0 of a frame; this drives the downstream filter's SET input.
REQ-013 frame_end  output  1  high with row_valid when row_out is row ROW-1.

Function
REQ-014 A pixel is accepted only on a rising edge with pix_valid=1 and pix_ready=1; a row is consumed only on an edge with row_valid=1 and row_ready=1.
REQ-015 Storage: one assembly register (COL pixels) plus one output register (row_out); total two rows.
REQ-016 Column counter col (0..COL-1) increments per accepted pixel; accepted pixel is written to assembly slot col.
REQ-017 Accepting the pixel at col=COL-1 completes the row; col wraps to 0 on that same edge.
REQ-018 On completion, when the output register is empty or is consumed on that same edge, the completed row (including the final pixel) moves to row_out and row_valid=1 on the next cycle; zero added latency.
REQ-019 Otherwise the assembly register is marked full; pix_ready=0 while full.
REQ-020 While full, the first edge on which row_out is consumed transfers assembly to row_out, keeps row_valid=1, clears full; pix_ready returns to 1 the following cycle.
REQ-021 pix_ready = NOT full; it does not depend combinationally on pix_valid.
REQ-022 row_valid falls after consumption only if no completed row is transferred on the same edge.
REQ-023 row_out, SET and frame_end stay stable while row_valid=1 and row_ready=0.
REQ-024 Row counter rcnt (0..ROW-1) tags each completed row; it increments on completion and wraps from ROW-1 to 0.
REQ-025 SET = row_valid AND (tag of row_out = 0); frame_end = row_valid AND (tag of row_out = ROW-1).
REQ-026 No pixel is dropped or duplicated under any valid/ready pattern; output row order equals input order.

Reset
REQ-027 RST=0 asynchronously clears col, rcnt, the full flag, row_valid, SET and frame_end, and sets row_out to all zeros.
REQ-028 pix_ready=1 from the first edge after RST returns to 1.
REQ-029 Reset mid-row discards the partial row; the first pixel after reset goes to slot 0 of row 0.
REQ-030 Assembly register contents are not reset; they are never observable before being overwritten.

Verification
REQ-031 COL=4, ROW=2, WIDTH=8; RST pulse; pixels 0x010101..0x040404 with row_ready=1 -> row_valid=1 the cycle after the 4th accept; row_out=0x010101020202030303040404; SET=1; frame_end=0.
REQ-032 row_ready=0; stream 8 pixels back-to-back -> row 0 held stable; after pixel 8, pix_ready=0; raise row_ready for 1 cycle -> row_out becomes row 1 with frame_end=1 and SET=0; pix_ready=1 on the next cycle.
REQ-033 Consume on the same edge the next row completes -> row_valid stays 1 continuously; no gap and no lost row.
REQ-034 Assert RST after 2 of 4 pixels -> all outputs 0; the next 4 pixels form a row with SET=1.
REQ-035 3 full frames with random pix_valid/row_ready -> scoreboard matches every pixel in order; SET and frame_end alternate per frame; rcnt wraps.

Source files
------------

// File: rtl/row_packer.sv
// ---------------------------------------------------------------------------
// row_packer : assembles a raster pixel stream into whole rows, two-row buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module row_packer #(
  parameter int COL   = 256,
  parameter int ROW   = 256,
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [3*WIDTH-1:0]     pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [COL*WIDTH*3-1:0] row_out,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic                   SET,
  output logic                   frame_end
);

  localparam int PW  = 3 * WIDTH;
  localparam int RW  = COL * PW;
  localparam int CW  = (COL > 1) ? $clog2(COL) : 1;
  localparam int RCW = (ROW > 1) ? $clog2(ROW) : 1;

  logic [RW-1:0]  asm_q, asm_d;
  logic [RW-1:0]  row_out_q, row_out_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [RCW-1:0] tag_q, tag_d;
  logic [RCW-1:0] ptag_q, ptag_d;
  logic           full_q, full_d;
  logic           row_valid_q, row_valid_d;

  logic accept, consume, last_col, complete;

  always_comb begin
    accept   = pix_valid && !full_q;
    consume  = row_valid_q && row_ready;
    last_col = (col_q == CW'(COL - 1));
    complete = accept && last_col;

    asm_d = asm_q;
    for (int i = 0; i < COL; i++) begin
      if (accept && (col_q == CW'(i))) begin
        asm_d[RW-1-i*PW -: PW] = pix_in;
      end
    end

    col_d = col_q;
    if (accept) begin
      col_d = last_col ? '0 : col_q + CW'(1);
    end

    rcnt_d = rcnt_q;
    if (complete) begin
      rcnt_d = (rcnt_q == RCW'(ROW - 1)) ? '0 : rcnt_q + RCW'(1);
    end

    full_d      = full_q;
    ptag_d      = ptag_q;
    row_out_d   = row_out_q;
    row_valid_d = row_valid_q;
    tag_d       = tag_q;

    if (consume) begin
      row_valid_d = 1'b0;
    end

    // A parked row always has priority; no pixel can be accepted while full.
    if (full_q && consume) begin
      row_out_d   = asm_q;
      tag_d       = ptag_q;
      row_valid_d = 1'b1;
      full_d      = 1'b0;
    end else if (complete) begin
      if (!row_valid_q || row_ready) begin
        row_out_d   = asm_d;
        tag_d       = rcnt_q;
        row_valid_d = 1'b1;
      end else begin
        full_d = 1'b1;
        ptag_d = rcnt_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_out_q   <= '0;
      col_q       <= '0;
      rcnt_q      <= '0;
      tag_q       <= '0;
      ptag_q      <= '0;
      full_q      <= 1'b0;
      row_valid_q <= 1'b0;
    end else begin
      row_out_q   <= row_out_d;
      col_q       <= col_d;
      rcnt_q      <= rcnt_d;
      tag_q       <= tag_d;
      ptag_q      <= ptag_d;
      full_q      <= full_d;
      row_valid_q <= row_valid_d;
    end
  end

  // Assembly storage is always overwritten before it can reach row_out.
  always_ff @(posedge CLK) begin
    asm_q <= asm_d;
  end

  assign pix_ready = !full_q;
  assign row_out   = row_out_q;
  assign row_valid = row_valid_q;
  assign SET       = row_valid_q && (tag_q == '0);
  assign frame_end = row_valid_q && (tag_q == RCW'(ROW - 1));

endmodule

`default_nettype wire

// File: tb/tb_row_packer.sv
// ---------------------------------------------------------------------------
// tb_row_packer : directed + randomised scoreboard bench for row_packer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_row_packer;

  logic        CLK;
  logic        RST;
  logic [23:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [95:0] row_out;
  logic        row_valid;
  logic        row_ready;
  logic        SET;
  logic        frame_end;

  row_packer #(.COL(4), .ROW(2), .WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .row_out   (row_out),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .SET       (SET),
    .frame_end (frame_end)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [95:0] row;
    logic        set;
    logic        fe;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          set_seen = 0;
  int          fe_seen  = 0;
  logic [95:0] part;
  int          part_n = 0;
  int          rcnt_m = 0;
  bit          stim_done;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Handshakes are judged at the falling edge; inputs only change just after rising edges.
  always @(negedge CLK) begin
    if (!RST) begin
      part_n = 0;
      rcnt_m = 0;
    end else begin
      if (row_valid && row_ready) begin
        if (q.size() == 0) begin
          chk("row_unexpected", row_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_row", row_out, e.row);
          chk("sb_set", SET, e.set);
          chk("sb_frame_end", frame_end, e.fe);
          if (SET) set_seen++;
          if (frame_end) fe_seen++;
        end
      end
      if (pix_valid && pix_ready) begin
        part[(3-part_n)*24 +: 24] = pix_in;
        part_n++;
        if (part_n == 4) begin
          exp_t e;
          e.row = part;
          e.set = (rcnt_m == 0);
          e.fe  = (rcnt_m == 1);
          q.push_back(e);
          rcnt_m = (rcnt_m + 1) % 2;
          part_n = 0;
        end
      end
    end
  end

  task automatic send_pix(input logic [23:0] v);
    int n;
    n = 0;
    pix_in    = v;
    pix_valid = 1'b1;
    while (1) begin
      @(negedge CLK);
      if (pix_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        chk("pix_ready_timeout", pix_ready, 1);
        break;
      end
    end
    @(posedge CLK); #1;
    pix_valid = 1'b0;
  endtask

  task automatic rst_pulse();
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    int s0, f0, guard;
    RST = 1'b0; pix_valid = 1'b0; pix_in = '0; row_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_set", SET, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_row_out", row_out, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_rst", pix_ready, 1);

    // First row straight through an empty output register
    row_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send_pix({3{8'(i)}});
    chk("r0_valid", row_valid, 1);
    chk("r0_row", row_out, 96'h010101020202030303040404);
    chk("r0_set", SET, 1);
    chk("r0_fe", frame_end, 0);
    @(posedge CLK); #1;
    chk("r0_drained", row_valid, 0);
    row_ready = 1'b0;
    rst_pulse();

    // Backpressure: second row parks in the assembly register
    for (int i = 0; i < 8; i++) begin
      send_pix({3{8'(8'h10 + i)}});
      if (i == 3) chk("bp_r0_first", row_out, 96'h101010111111121212131313);
    end
    chk("bp_valid", row_valid, 1);
    chk("bp_r0_stable", row_out, 96'h101010111111121212131313);
    chk("bp_set_stable", SET, 1);
    chk("bp_ready_low", pix_ready, 0);
    row_ready = 1'b1;
    @(posedge CLK); #1;
    row_ready = 1'b0;
    chk("bp_r1_valid", row_valid, 1);
    chk("bp_r1_row", row_out, 96'h141414151515161616171717);
    chk("bp_r1_set", SET, 0);
    chk("bp_r1_fe", frame_end, 1);
    chk("bp_ready_back", pix_ready, 1);
    row_ready = 1'b1;
    @(posedge CLK); #1;
    row_ready = 1'b0;
    chk("bp_drained", row_valid, 0);

    // Consume on the same edge the next row completes
    for (int i = 0; i < 7; i++) send_pix({3{8'(8'h20 + i)}});
    row_ready = 1'b1;
    send_pix(24'h272727);
    chk("same_edge_valid", row_valid, 1);
    chk("same_edge_row", row_out, 96'h242424252525262626272727);
    chk("same_edge_fe", frame_end, 1);
    @(posedge CLK); #1;
    row_ready = 1'b0;
    chk("same_edge_drained", row_valid, 0);
    chk("sb_empty_pre_rst", q.size(), 0);

    // Reset in the middle of a row
    row_ready = 1'b1;
    send_pix(24'h303030);
    send_pix(24'h313131);
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", row_valid, 0);
    chk("mid_rst_row", row_out, 0);
    chk("mid_rst_set", SET, 0);
    chk("mid_rst_fe", frame_end, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) send_pix({3{8'(8'h40 + i)}});
    chk("post_rst_valid", row_valid, 1);
    chk("post_rst_row", row_out, 96'h404040414141424242434343);
    chk("post_rst_set", SET, 1);
    @(posedge CLK); #1;

    // Three frames with random valid/ready
    s0 = set_seen;
    f0 = fe_seen;
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge CLK);
          #1;
          send_pix(24'($urandom));
        end
        stim_done = 1'b1;
      end
      begin
        guard = 0;
        while (!(stim_done && q.size() == 0) && guard < 3000) begin
          @(posedge CLK); #1;
          row_ready = 1'($urandom_range(0, 1));
          guard++;
        end
      end
    join
    row_ready = 1'b0;
    chk("rand_sb_empty", q.size(), 0);
    chk("rand_set_count", set_seen - s0, 3);
    chk("rand_fe_count", fe_seen - f0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
